// File: rtl/lauflicht_avalon_slave.sv
// lauflicht_avalon_slave: Avalon-MM register block driving a running-light LED output
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   address_i      byte address; hit when [31:4] matches BASE_ADDR, register select [3:2]
//   read_i         read request (1-cycle latency, answered with readdatavalid_o)
//   write_i        write request (zero wait states)
//   byteenable_i   write byte lanes
//   writedata_i    write data
//   readdata_o     read data, held until the next response
//   readdatavalid_o one-cycle read response pulse
//   waitrequest_o  high in reset and on the first edge after it, low thereafter
//   led_o          current running-light pattern
//
// Registers: 0x0 CTRL {bounce,dir,enable}, 0x4 PERIOD, 0x8 PATTERN, 0xC STATUS (step count)
// Optional: define LAUFLICHT_BOUNCE_EN to make CTRL[2] writable and enable bounce mode.
module lauflicht_avalon_slave #(
    parameter int          NUM_LEDS       = 8,
    parameter int          PRESC_W        = 24,
    parameter int          DEFAULT_PERIOD = 12000000,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    output logic [31:0]         readdata_o,
    output logic                readdatavalid_o,
    output logic                waitrequest_o,
    input  logic                write_i,
    input  logic [3:0]          byteenable_i,
    input  logic [31:0]         writedata_i,
    output logic [NUM_LEDS-1:0] led_o
);
`ifdef LAUFLICHT_BOUNCE_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    logic                wait_q, rvalid_q;
    logic [31:0]         rdata_q, rdata_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic [PRESC_W-1:0]  period_q, period_d, cnt_q, cnt_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [15:0]         status_q, status_d;

    logic        hit, wr_hit, rd_acc, tick;
    logic [1:0]  sel;
    logic [31:0] period_x, pattern_x, reg_rd, wr_val;
    logic        unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    assign hit       = address_i[31:4] == BASE_ADDR[31:4];
    assign sel       = address_i[3:2];
    assign wr_hit    = write_i && !wait_q && hit;
    assign rd_acc    = read_i && !write_i && !wait_q;
    assign unused_ok = ^{address_i[1:0], wr_val};

    always_comb begin
        period_x = '0;
        period_x[PRESC_W-1:0] = period_q;
        pattern_x = '0;
        pattern_x[NUM_LEDS-1:0] = pattern_q;
        reg_rd = sel == 2'd0 ? {29'b0, ctrl_q} :
                 sel == 2'd1 ? period_x :
                 sel == 2'd2 ? pattern_x : {16'b0, status_q};
        wr_val  = merge(reg_rd, writedata_i, byteenable_i);
        rdata_d = rd_acc ? (hit ? reg_rd : 32'b0) : rdata_q;
    end

    // Any register write in a tick cycle swallows the tick; CTRL/PERIOD writes also restart the count.
    always_comb begin
        ctrl_d    = ctrl_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        status_d  = status_q;
        tick      = ctrl_q[0] && cnt_q == period_q;
        cnt_d     = (!ctrl_q[0] || tick || (wr_hit && !sel[1])) ? '0 : cnt_q + PRESC_W'(1);
        if (wr_hit) begin
            if (sel == 2'd0) ctrl_d = wr_val[2:0] & CTRL_MASK;
            if (sel == 2'd1) period_d = wr_val[PRESC_W-1:0];
            if (sel == 2'd2) pattern_d = wr_val[NUM_LEDS-1:0];
            if (sel == 2'd3) status_d = '0;
        end else if (tick) begin
            status_d  = status_q + 16'd1;
            pattern_d = ctrl_q[1] ? {pattern_q[0], pattern_q[NUM_LEDS-1:1]}
                                  : {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
`ifdef LAUFLICHT_BOUNCE_EN
            // Bounce: reverse when the lit edge bit is reached, shifting logically.
            if (ctrl_q[2]) begin
                ctrl_d[1] = ctrl_q[1] ^ (ctrl_q[1] ? pattern_q[0] : pattern_q[NUM_LEDS-1]);
                pattern_d = ctrl_d[1] ? pattern_q >> 1 : pattern_q << 1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            period_q  <= PRESC_W'(DEFAULT_PERIOD);
            pattern_q <= NUM_LEDS'(1);
            status_q  <= '0;
            cnt_q     <= '0;
        end else begin
            wait_q    <= 1'b0;
            rvalid_q  <= rd_acc;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            status_q  <= status_d;
            cnt_q     <= cnt_d;
        end
    end

    assign readdata_o      = rdata_q;
    assign readdatavalid_o = rvalid_q;
    assign waitrequest_o   = wait_q;
    assign led_o           = pattern_q;
endmodule

// File: doc/lauflicht_avalon_slave.md
Name: lauflicht_avalon_slave

Overview:
- Avalon-MM slave register block that sits directly downstream of the I2C target's Avalon-MM master port.
- Holds control, period and pattern registers written over I2C.
- Drives an N-bit running-light (Lauflicht) LED output from a programmable prescaler.
- Zero-wait-state writes; fixed read latency of 1 cycle with readdatavalid.

Parameters:
- NUM_LEDS, 8, width of LED pattern / led output (2..32)
- PRESC_W, 24, width of prescaler counter and PERIOD register (1..32)
- DEFAULT_PERIOD, 12000000, PERIOD reset value (fits PRESC_W)
- BASE_ADDR, 32'h0000_0000, byte base of the 16-byte register window (16-byte aligned)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- address  in  32  byte address from master
- read  in  1  read request
- readdata  out  32  read data, valid when readdatavalid=1
- readdatavalid  out  1  one-cycle pulse, read response
- waitrequest  out  1  slave stall
- write  in  1  write request
- byteenable  in  4  byte lanes for write
- writedata  in  32  write data
- led  out  NUM_LEDS  current pattern

Behaviour:
- Reset (async, rst=1): CTRL=0, PERIOD=DEFAULT_PERIOD, PATTERN=1 (led=1), STATUS=0, prescaler=0, readdata=0, readdatavalid=0, waitrequest=1. First clock edge with rst=0 drops waitrequest to 0; it stays 0 thereafter.
- Decode: hit when address[31:4]==BASE_ADDR[31:4]. Register select is address[3:2]; address[1:0] is ignored.
- Register map:
  - 0x0 CTRL: [0] enable, [1] dir (0 = toward MSB), [2] bounce; other bits read 0.
  - 0x4 PERIOD: [PRESC_W-1:0].
  - 0x8 PATTERN: [NUM_LEDS-1:0] live pattern.
  - 0xC STATUS: [15:0] step count, read-only; any write clears it to 0.
- Write, accepted when write=1 and waitrequest=0: each byte lane with byteenable[i]=1 updates bits [8i+7:8i] of the selected register. Unimplemented bits are dropped. Miss writes are discarded.
- Read, accepted when read=1, write=0, waitrequest=0: register value sampled in the acceptance cycle.
  - Next cycle: readdatavalid=1 with readdata. readdata holds until the next response.
  - A miss returns 0 but still asserts readdatavalid, so the master never hangs.
  - Back-to-back reads give back-to-back responses.
- read and write both 1: write performed, read dropped, no readdatavalid.
- Prescaler, while enable=1:
  - counter increments each cycle; when counter==PERIOD it emits a tick and clears to 0. PERIOD=0 gives a tick every cycle.
  - enable=0: counter holds at 0 and no ticks occur.
  - A write to PERIOD or CTRL clears the counter.
- On tick:
  - dir=0: pattern rotates left, bit NUM_LEDS-1 wraps to bit 0.
  - dir=1: pattern rotates right, bit 0 wraps to bit NUM_LEDS-1.
  - STATUS increments, wrapping 0xFFFF->0x0000.
  - Pattern 0 stays 0, but STATUS still counts.
- Same-cycle collisions: a write to PATTERN or STATUS in a tick cycle wins (written value loaded, no rotate/increment). CTRL or PERIOD writes in a tick cycle still suppress the tick.
- led is a registered copy of PATTERN, same cycle as the register.
- Reset mid-read: a pending readdatavalid is cancelled.

Optional Feature:
- Macro: LAUFLICHT_BOUNCE_EN.
- Defined:
  - CTRL[2] is writable.
  - When bounce=1 and dir=0, a tick with pattern[NUM_LEDS-1]=1 sets dir=1 and shifts right in the same tick; mirrored at bit 0.
  - Bounce shifts are logical (no wrap).
  - The hardware dir flip is visible in CTRL[1].
- Undefined: CTRL[2] reads 0 and writes are ignored; rotate only.

Test Plan:
- Reset release: led=0x01, waitrequest 1->0 on first edge, then read 0x4 -> readdata=12000000 one cycle later with readdatavalid pulse.
- Write PERIOD=3, CTRL=0x1: led steps 0x01->0x02->0x04 every 4 cycles. After 8 ticks led=0x01 and STATUS=8.
- CTRL=0x3 (dir right), PATTERN=0x81, PERIOD=0: led 0x81->0xC0->0x60 on consecutive cycles.
- Byte lanes: write PERIOD=0xAABBCC with byteenable=4'b0010 over 0x000000 -> PERIOD reads 0x00BB00. A miss address 0x100 write leaves all registers unchanged, and a miss read returns 0 with readdatavalid.
- Collision: PATTERN write 0x0F in tick cycle -> led=0x0F next cycle, STATUS unchanged. Simultaneous read+write -> write applied, no readdatavalid.
- With LAUFLICHT_BOUNCE_EN, CTRL=0x5, PATTERN=0x40, PERIOD=0:
  - led goes 0x40, 0x80, then 0x40 with CTRL[1]=1.
  - Without the macro, CTRL reads 0x1 and led goes 0x80->0x01.
